// File: rtl/sha_miner_defs_pkg.sv
// Definitions shared by the SHA-256 miner blocks: datapath widths, the hasher
// pipeline depth and the solution record that is queued towards the host.
package sha_miner_defs;

  localparam int HASH_W       = 256;
  localparam int WORD_W       = 32;
  localparam int PIPE_LAT_DEF = 130;
  localparam int SOL_W        = 128;

  typedef struct packed {
    logic [WORD_W-1:0] tstamp;
    logic [WORD_W-1:0] nonce;
    logic [63:0]       hash;
  } sol_t;

  // The {time,nonce} counter runs lat words ahead of the result it belongs to.
  function automatic logic [2*WORD_W-1:0] skew_correct(input logic [2*WORD_W-1:0] ctr,
                                                       input int lat);
    return ctr - (2*WORD_W)'(lat);
  endfunction

endpackage

// File: rtl/sha_solution_collector_sol_fifo.sv
// Synchronous single-clock FIFO for solution records; extra pointer MSB
// distinguishes full from empty.
module sol_fifo #(
  parameter int W     = 128,
  parameter int DEPTH = 4
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       clr,
  input  logic                       push,
  input  logic                       pop,
  input  logic [W-1:0]               wdata,
  output logic [W-1:0]               rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wr_q, rd_q;
  logic         do_pop, do_push;

  assign empty   = (wr_q == rd_q);
  assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign count   = wr_q - rd_q;
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem_q[rd_q[AW-1:0]];

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      wr_q <= '0;
      rd_q <= '0;
    end else if (clr) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
    end
  end

  // NOTE: storage is deliberately not reset; the pointers alone define which entries are valid.
  always_ff @(posedge CLK) begin
    if (do_push && !clr) mem_q[wr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/sha_solution_collector.sv
// Hasher result consumer: target compare, counter skew correction and a
// solution FIFO drained by the host over valid/ready.
import sha_miner_defs::*;

module sha_solution_collector #(
  parameter int PIPE_LAT  = PIPE_LAT_DEF,
  parameter int DEPTH     = 4,
  parameter int AFULL_GAP = 2
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              clr,
  input  logic              valid_in,
  input  logic [HASH_W-1:0] result_in,
  input  logic [WORD_W-1:0] time_in,
  input  logic [WORD_W-1:0] nonce_in,
  input  logic [HASH_W-1:0] target_in,
  output logic              hold_out,
  output logic              sol_valid,
  input  logic              sol_ready,
  output logic [WORD_W-1:0] sol_time,
  output logic [WORD_W-1:0] sol_nonce,
  output logic [63:0]       sol_hash,
  output logic [WORD_W-1:0] hit_count,
  output logic              drop_flag
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic              s1_valid_q, s1_hit_q;
  sol_t              s1_rec_q;
  logic [2*WORD_W-1:0] corr;
  logic              fifo_full, fifo_empty;
  logic [CW-1:0]     fifo_count, count_d;
  logic [SOL_W-1:0]  fifo_rdata;
  sol_t              head;
  logic              pop, push, drop;
  logic              hold_q, drop_q;
  logic [WORD_W-1:0] hit_count_q;

  assign corr = skew_correct({time_in, nonce_in}, PIPE_LAT);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      s1_valid_q <= 1'b0;
      s1_hit_q   <= 1'b0;
      s1_rec_q   <= '0;
    end else if (clr) begin
      s1_valid_q <= 1'b0;
    end else begin
      s1_valid_q <= valid_in;
      if (valid_in) begin
        s1_hit_q <= (result_in <= target_in);
        s1_rec_q <= '{tstamp: corr[2*WORD_W-1:WORD_W], nonce: corr[WORD_W-1:0],
                      hash: result_in[HASH_W-1 -: 64]};
      end
    end
  end

  // A pop in the same cycle frees the slot, so a full FIFO still accepts the hit.
  assign pop     = sol_ready & ~fifo_empty;
  assign push    = s1_valid_q & s1_hit_q & (~fifo_full | pop);
  assign drop    = s1_valid_q & s1_hit_q & fifo_full & ~pop;
  assign count_d = clr ? '0 : fifo_count + CW'(push) - CW'(pop);

  sol_fifo #(.W(SOL_W), .DEPTH(DEPTH)) u_fifo (
    .CLK   (CLK),
    .RST   (RST),
    .clr   (clr),
    .push  (push),
    .pop   (pop),
    .wdata (s1_rec_q),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      hold_q      <= 1'b0;
      drop_q      <= 1'b0;
      hit_count_q <= '0;
    end else begin
      hold_q <= ((DEPTH - int'(count_d)) <= AFULL_GAP);
      if (clr) begin
        drop_q      <= 1'b0;
        hit_count_q <= '0;
      end else begin
        if (drop) drop_q <= 1'b1;
        if (push && hit_count_q != '1) hit_count_q <= hit_count_q + WORD_W'(1);
      end
    end
  end

  assign head      = sol_t'(fifo_rdata);
  assign sol_valid = ~fifo_empty;
  assign sol_time  = fifo_empty ? '0 : head.tstamp;
  assign sol_nonce = fifo_empty ? '0 : head.nonce;
  assign sol_hash  = fifo_empty ? '0 : head.hash;
  assign hold_out  = hold_q;
  assign hit_count = hit_count_q;
  assign drop_flag = drop_q;

endmodule

// File: tb/tb_sha_solution_collector.sv
// Self-checking bench: directed scenarios with literal expectations plus a
// randomized run compared every cycle against a queue-based reference model.
module tb_sha_solution_collector;
  import sha_miner_defs::*;

  localparam int DEPTH = 4;
  localparam int GAP   = 2;
  localparam int LAT   = 130;

  logic         CLK = 1'b0;
  logic         RST = 1'b0;
  logic         clr = 1'b0;
  logic         valid_in = 1'b0;
  logic         sol_ready = 1'b0;
  logic [255:0] result_in = '0;
  logic [255:0] target_in;
  logic [31:0]  time_in = '0;
  logic [31:0]  nonce_in = '0;
  logic         hold_out, sol_valid, drop_flag;
  logic [31:0]  sol_time, sol_nonce, hit_count;
  logic [63:0]  sol_hash;

  logic [255:0] t_def;

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  sha_solution_collector #(.PIPE_LAT(LAT), .DEPTH(DEPTH), .AFULL_GAP(GAP)) dut (
    .CLK(CLK), .RST(RST), .clr(clr), .valid_in(valid_in), .result_in(result_in),
    .time_in(time_in), .nonce_in(nonce_in), .target_in(target_in), .hold_out(hold_out),
    .sol_valid(sol_valid), .sol_ready(sol_ready), .sol_time(sol_time), .sol_nonce(sol_nonce),
    .sol_hash(sol_hash), .hit_count(hit_count), .drop_flag(drop_flag)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of solutions plus the one result in flight.
  typedef struct { logic [63:0] corr; logic [63:0] hash; } rec_t;
  rec_t        q[$];
  bit          pend_v, pend_hit;
  rec_t        pend_rec;
  logic [31:0] m_hc;
  bit          m_drop;

  always @(posedge CLK or negedge RST) begin
    if (!RST || clr) begin
      q.delete();
      pend_v = 1'b0;
      m_hc   = '0;
      m_drop = 1'b0;
    end else begin
      if (sol_ready && q.size() > 0) void'(q.pop_front());
      if (pend_v && pend_hit) begin
        if (q.size() < DEPTH) begin
          q.push_back(pend_rec);
          if (m_hc != 32'hFFFF_FFFF) m_hc = m_hc + 1;
        end else begin
          m_drop = 1'b1;
        end
      end
      pend_v = valid_in;
      if (valid_in) begin
        pend_hit      = (result_in <= target_in);
        pend_rec.corr = {time_in, nonce_in} - 64'(LAT);
        pend_rec.hash = result_in[255:192];
      end
    end
  end

  always @(negedge CLK) begin
    if (chk_en && RST) begin
      rec_t h;
      bit   v;
      v = (q.size() > 0);
      h.corr = '0;
      h.hash = '0;
      if (v) h = q[0];
      check("m_sol_valid", 64'(sol_valid), 64'(v));
      check("m_sol_time",  64'(sol_time),  64'(h.corr[63:32]));
      check("m_sol_nonce", 64'(sol_nonce), 64'(h.corr[31:0]));
      check("m_sol_hash",  sol_hash,       h.hash);
      check("m_hit_count", 64'(hit_count), 64'(m_hc));
      check("m_drop_flag", 64'(drop_flag), 64'(m_drop));
      check("m_hold_out",  64'(hold_out),  64'((DEPTH - q.size()) <= GAP));
    end
  end

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic send(input logic [255:0] r, input logic [31:0] t, input logic [31:0] n);
    valid_in  = 1'b1;
    result_in = r;
    time_in   = t;
    nonce_in  = n;
    cyc();
    valid_in  = 1'b0;
  endtask

  task automatic pop1();
    sol_ready = 1'b1;
    cyc();
    sol_ready = 1'b0;
  endtask

  function automatic logic [255:0] rand256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    t_def     = {32'h0, {224{1'b1}}};
    target_in = t_def;

    // Reset state
    repeat (3) cyc();
    @(negedge CLK);
    check("rst_sol_valid", 64'(sol_valid), 64'd0);
    check("rst_hit_count", 64'(hit_count), 64'd0);
    check("rst_hold",      64'(hold_out),  64'd0);
    check("rst_drop",      64'(drop_flag), 64'd0);
    check("rst_sol_time",  64'(sol_time),  64'd0);
    cyc();
    RST    = 1'b1;
    chk_en = 1'b1;

    // Single hit, exact two-edge latency
    send('0, 32'd0, 32'd200);
    @(negedge CLK);
    check("lat_not_early", 64'(sol_valid), 64'd0);
    cyc();
    @(negedge CLK);
    check("single_valid", 64'(sol_valid), 64'd1);
    check("single_nonce", 64'(sol_nonce), 64'd70);
    check("single_time",  64'(sol_time),  64'd0);
    check("single_count", 64'(hit_count), 64'd1);
    pop1();
    @(negedge CLK);
    check("single_popped", 64'(sol_valid), 64'd0);

    // Boundary: target+1 misses, target hits
    send({32'h1, 224'h0}, 32'd0, 32'd300);
    repeat (2) cyc();
    @(negedge CLK);
    check("miss_valid", 64'(sol_valid), 64'd0);
    check("miss_count", 64'(hit_count), 64'd1);
    send(t_def, 32'd0, 32'd300);
    cyc();
    @(negedge CLK);
    check("eq_valid", 64'(sol_valid), 64'd1);
    check("eq_hash",  sol_hash,       64'h0000_0000_FFFF_FFFF);
    check("eq_count", 64'(hit_count), 64'd2);
    pop1();

    // Skew correction with borrow
    send('0, 32'd7, 32'd5);
    cyc();
    @(negedge CLK);
    check("borrow_time",  64'(sol_time),  64'd6);
    check("borrow_nonce", 64'(sol_nonce), 64'hFFFF_FF83);
    pop1();
    send('0, 32'd0, 32'd5);
    cyc();
    @(negedge CLK);
    check("wrap_time",  64'(sol_time),  64'hFFFF_FFFF);
    check("wrap_nonce", 64'(sol_nonce), 64'hFFFF_FF83);
    pop1();

    // Backpressure: six hits, no drain
    for (int i = 0; i < 6; i++) begin
      valid_in  = 1'b1;
      result_in = '0;
      time_in   = '0;
      nonce_in  = 32'd1000 + 32'(i);
      cyc();
      if (i == 1) begin
        @(negedge CLK);
        check("hold_after_1", 64'(hold_out), 64'd0);
      end
      if (i == 2) begin
        @(negedge CLK);
        check("hold_after_2", 64'(hold_out), 64'd1);
      end
    end
    valid_in = 1'b0;
    repeat (2) cyc();
    @(negedge CLK);
    check("bp_drop",  64'(drop_flag), 64'd1);
    check("bp_count", 64'(hit_count), 64'd8);
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      check("bp_order", 64'(sol_nonce), 64'(870 + i));
      pop1();
    end
    @(negedge CLK);
    check("bp_empty", 64'(sol_valid), 64'd0);

    // Full FIFO with pop in the cycle of a push
    clr = 1'b1;
    cyc();
    clr = 1'b0;
    @(negedge CLK);
    check("clr_drop",  64'(drop_flag), 64'd0);
    check("clr_count", 64'(hit_count), 64'd0);
    for (int i = 0; i < 5; i++) begin
      valid_in = 1'b1;
      nonce_in = 32'd2000 + 32'(i);
      cyc();
    end
    valid_in  = 1'b0;
    sol_ready = 1'b1;
    cyc();
    sol_ready = 1'b0;
    @(negedge CLK);
    check("fullpop_drop",  64'(drop_flag), 64'd0);
    check("fullpop_count", 64'(hit_count), 64'd5);
    check("fullpop_hold",  64'(hold_out),  64'd1);
    check("fullpop_head",  64'(sol_nonce), 64'd1871);
    for (int i = 0; i < 4; i++) pop1();
    @(negedge CLK);
    check("fullpop_empty", 64'(sol_valid), 64'd0);

    // clr together with an incoming hit
    for (int i = 0; i < 3; i++) begin
      valid_in = 1'b1;
      nonce_in = 32'd3000 + 32'(i);
      cyc();
    end
    valid_in = 1'b0;
    cyc();
    @(negedge CLK);
    check("pre_clr_count", 64'(hit_count), 64'd8);
    valid_in = 1'b1;
    clr      = 1'b1;
    cyc();
    valid_in = 1'b0;
    clr      = 1'b0;
    @(negedge CLK);
    check("clr_valid", 64'(sol_valid), 64'd0);
    check("clr_hc",    64'(hit_count), 64'd0);
    check("clr_hold",  64'(hold_out),  64'd0);
    cyc();
    @(negedge CLK);
    check("clr_s1_gone", 64'(sol_valid), 64'd0);

    // Asynchronous reset mid-stream
    for (int i = 0; i < 3; i++) begin
      valid_in = 1'b1;
      nonce_in = 32'd4000 + 32'(i);
      cyc();
    end
    valid_in = 1'b1;
    @(negedge CLK);
    #2;
    RST = 1'b0;
    #1;
    check("arst_valid", 64'(sol_valid), 64'd0);
    check("arst_hc",    64'(hit_count), 64'd0);
    check("arst_hold",  64'(hold_out),  64'd0);
    check("arst_drop",  64'(drop_flag), 64'd0);
    valid_in = 1'b0;
    repeat (2) cyc();
    RST = 1'b1;

    // Randomized segments with different targets
    for (int seg = 0; seg < 3; seg++) begin
      if (seg == 0) target_in = t_def;
      else if (seg == 1) target_in = '1;
      else begin
        target_in = rand256();
        target_in[255] = 1'b0;
      end
      repeat (2) cyc();
      for (int c = 0; c < 200; c++) begin
        valid_in  = $urandom_range(0, 1) == 1;
        result_in = rand256();
        if (seg == 0 && $urandom_range(0, 2) == 0) result_in[255:224] = '0;
        time_in   = (c % 5 == 0) ? 32'd0 : $urandom;
        nonce_in  = (c % 7 == 0) ? 32'(c) : $urandom;
        sol_ready = $urandom_range(0, 2) == 0;
        clr       = $urandom_range(0, 63) == 0;
        cyc();
      end
      valid_in  = 1'b0;
      clr       = 1'b0;
      sol_ready = 1'b1;
      repeat (6) cyc();
      sol_ready = 1'b0;
    end

    @(negedge CLK);
    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
